// File: rtl/ttt_sparse_sweep_scheduler.sv
// ttt_sparse_sweep_scheduler
// Collects event bits into a pending vector. On start it snapshots that vector
// and issues the index of each set bit, lowest first, over a valid/ready
// handshake. Events that arrive during a sweep are kept for the next sweep.
// Optional feature: define TTT_SCHED_OVERFLOW_EN to enable the sticky overflow
// flag. It flags an event that merged into a bit that was already pending.
module ttt_sparse_sweep_scheduler #(
  parameter  int SIZE  = 8,
  localparam int IDX_W = $clog2(SIZE),
  localparam int CNT_W = $clog2(SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SIZE-1:0]  ev_in,
  input  logic             ev_strobe,
  input  logic             start,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy,
  output logic             done,
  output logic             pending_nonempty,
  output logic [CNT_W-1:0] issued_count,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  state_t          state;
  logic [SIZE-1:0] pending;
  logic [SIZE-1:0] snap;
  logic [SIZE-1:0] snap_next;
  logic [SIZE-1:0] pending_masked;
  logic            start_acc;

  // A start is only honoured in IDLE; it also wipes the pending vector,
  // because that vector is moved into the snapshot at the same edge.
  assign start_acc      = start && (state == IDLE);
  assign pending_masked = start_acc ? '0 : pending;

  // Clearing the lowest set bit removes the index being issued right now.
  assign snap_next        = snap & (snap - ONE);
  assign pending_nonempty = |pending;

  // Lowest set bit of the snapshot selects the index on offer.
  always_comb begin
    out_idx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (snap[i]) out_idx = IDX_W'(i);
    end
  end

  // Pending vector: events accumulate here, even while a sweep is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_masked | (ev_strobe ? ev_in : '0);
    end
  end

  // Sweep sequencer with its registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      snap         <= '0;
      issued_count <= '0;
      out_valid    <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            issued_count <= '0;
            busy         <= 1'b1;
            if (pending != '0) begin
              snap      <= pending;
              out_valid <= 1'b1;
              state     <= ISSUE;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        ISSUE: begin
          if (out_ready) begin
            snap         <= snap_next;
            issued_count <= issued_count + CNT_W'(1);
            if (snap_next == '0) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef TTT_SCHED_OVERFLOW_EN
  logic ovf_set;

  assign ovf_set = ev_strobe && ((ev_in & pending_masked) != '0);

  // Sticky collision flag; a new collision outranks the clear from a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (start_acc) begin
      overflow <= 1'b0;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: doc/ttt_sparse_sweep_scheduler.md
Name: ttt_sparse_sweep_scheduler

Overview:
Sequences sparse-event processing for the TTT datapath. Accumulates incoming event bits into a pending vector. On request, it snapshots that vector and issues the index of every set bit, lowest index first, over a valid/ready handshake. New events that arrive during a sweep are held for the next sweep. It sits between event sources and the per-index compute stage that consumes one index per cycle.

Parameters:
SIZE, 8, number of event lines; power of two, >= 2
IDX_W, $clog2(SIZE), width of issued index (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
ev_in  input  SIZE  event bits, sampled only when ev_strobe=1
ev_strobe  input  1  OR ev_in into pending vector this cycle
start  input  1  begin a sweep; accepted only in IDLE
out_ready  input  1  consumer accepts out_idx this cycle
out_valid  output  1  out_idx is valid
out_idx  output  IDX_W  index of lowest set bit in current snapshot
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at end of sweep
pending_nonempty  output  1  |pending (registered pending vector)
issued_count  output  $clog2(SIZE+1)  indices issued in current/last sweep
overflow  output  1  sticky event-collision flag (see Optional Feature); 0 when feature off

Behaviour:
- Registers: pending P[SIZE], snapshot S[SIZE], state, issued_count, overflow.
- Reset (rst_n=0, async): P=0, S=0, state=IDLE, issued_count=0, overflow=0. Outputs out_valid=0, out_idx=0, busy=0, done=0, pending_nonempty=0. Reset mid-sweep discards the snapshot and all pending events.
- Pending update: each edge, P <= (P & ~clear_mask) | (ev_strobe ? ev_in : 0).
  - clear_mask = all-ones when a start is accepted; otherwise 0.
  - Hence ev_strobe in the same cycle as an accepted start lands in the new P, not in S.
- FSM states:
  - IDLE: out_valid=0.
    - start=1 and P!=0 -> S<=P, issued_count<=0, go to ISSUE.
    - start=1 and P==0 -> issued_count<=0, go to DONE.
  - ISSUE: out_valid=1; out_idx = combinational priority encode (lowest set bit) of S.
    - On out_valid&out_ready: clear that bit in S and increment issued_count.
    - If the resulting S==0 -> DONE; else stay in ISSUE.
  - DONE: done=1 for exactly one cycle, out_valid=0 -> IDLE.
- start outside IDLE is ignored and not queued.
- Latency: start accepted at edge t -> out_valid=1 from cycle t+1.
- Throughput: one index per cycle with out_ready held high. With K set bits and no stalls, done is asserted in cycle t+K+1.
- Handshake: once asserted, out_valid stays high and out_idx stays stable until accepted. No withdrawal.
- ev_strobe during ISSUE/DONE affects P only, never S.
- issued_count holds its value after DONE until the next accepted start.
- Maximum issued_count is SIZE (all bits set); no wrap.

Optional Feature:
Macro TTT_SCHED_OVERFLOW_EN.
- Defined: overflow sets when ev_strobe=1 and (ev_in & P_masked) != 0, where P_masked is P after the same cycle's clear_mask. This flags an event lost by merging into an already-pending bit. The flag is sticky and cleared only by reset or an accepted start; if set and cleared in the same cycle, set wins.
- Undefined: the overflow port is driven constant 0 and no register is inferred.

Test Plan:
- Reset: assert rst_n=0 mid-sweep (state ISSUE, S=8'b1010_0000) -> all outputs 0 immediately, before the next clock edge. After release, pending_nonempty=0 and start gives done at t+1.
- Basic sweep (SIZE=8): ev_in=8'b1010_0100 strobed, start at t, out_ready=1 -> out_idx 2,5,7 in cycles t+1..t+3, done=1 at t+4, issued_count=3, busy low at t+5.
- Backpressure: same events, out_ready=0 for cycles t+1..t+3 -> out_valid=1 and out_idx=2 held stable. Index 5 appears the cycle after out_ready rises.
- Event during sweep: strobe ev_in=8'b0000_0010 at t+2 of the basic sweep -> index 1 not issued this sweep, pending_nonempty=1 after the sweep. The next start issues only index 1, issued_count=1.
- Empty start: P=0, start at t -> done=1 at t+1, out_valid never high, issued_count=0. A start during ISSUE has no effect on the sequence.
- With TTT_SCHED_OVERFLOW_EN: strobe 8'b0000_0100 twice before start -> overflow=1 and holds. The next accepted start clears it. Without the macro, overflow stays 0 throughout.
